// File: rtl/cmsdk_fpga_sram_ext.sv
// ---------------------------------------------------------------------------
// cmsdk_fpga_sram_ext
//   Parametrised single-port FPGA block-RAM with per-byte write enables,
//   configurable read latency (1 or 2), optional zero-fill after reset and
//   a read-return strobe.
//
// Parameters
//   AW         word-address width, depth = 2**AW
//   DW         data width (multiple of 8, 8..128), NB = DW/8 byte lanes
//   RD_LAT     read latency, 1 or 2 cycles
//   INIT_CLEAR 1 = zero-fill the whole array after reset
//   MEMFILE    preload file base name; a non-empty value disables the fill
//
// Ports
//   CLK     clock, rising edge
//   RESETn  asynchronous active-low reset
//   ADDR    word address
//   WDATA   write data
//   WREN    per-lane write enables (all zero = read)
//   CS      access select
//   RDATA   read data, zero whenever RVALID is low
//   RVALID  one-cycle strobe per returned read
//   READY   high once accesses are accepted
//
// Optional build macro CMSDK_SRAM_PARITY_EN adds one even-parity bit per
// lane, input PINJ (invert stored parity of written lanes) and output
// PERR (parity mismatch flag, qualified by RVALID).
// ---------------------------------------------------------------------------
module cmsdk_fpga_sram_ext #(
  parameter int unsigned AW         = 14,
  parameter int unsigned DW         = 32,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned INIT_CLEAR = 1,
  parameter string       MEMFILE    = ""
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic [AW-1:0]     ADDR,
  input  logic [DW-1:0]     WDATA,
  input  logic [DW/8-1:0]   WREN,
  input  logic              CS,
`ifdef CMSDK_SRAM_PARITY_EN
  input  logic              PINJ,
  output logic              PERR,
`endif
  output logic [DW-1:0]     RDATA,
  output logic              RVALID,
  output logic              READY
);

  localparam int unsigned NB     = DW / 8;
  localparam int unsigned DEPTH  = 1 << AW;
  localparam bit          CLR_EN = (INIT_CLEAR != 0) && (MEMFILE == "");

  if ((RD_LAT != 1) && (RD_LAT != 2)) begin : g_bad_rd_lat
    $error("cmsdk_fpga_sram_ext: RD_LAT must be 1 or 2");
  end
  if (((DW % 8) != 0) || (DW < 8) || (DW > 128)) begin : g_bad_dw
    $error("cmsdk_fpga_sram_ext: DW must be a multiple of 8 in 8..128");
  end

  // -------------------------------------------------------------------------
  // Zero-fill state machine
  // -------------------------------------------------------------------------
  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          ready_q, ready_d;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      ST_CLEAR: begin
        // Counter holds at the last address; the state change ends the fill.
        if (clr_cnt_q == '1) state_d = ST_RUN;
        else                 clr_cnt_d = clr_cnt_q + AW'(1);
      end
      default: ;
    endcase
    ready_d = (state_d == ST_RUN);
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q   <= CLR_EN ? ST_CLEAR : ST_RUN;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
    end
  end

  assign READY = ready_q;

  // -------------------------------------------------------------------------
  // Access decode
  // -------------------------------------------------------------------------
  logic          clearing;
  logic          acc;
  logic          rd_acc;
  logic [NB-1:0] wr_lane;

  always_comb begin
    clearing = (state_q == ST_CLEAR);
    acc      = CS & ready_q;
    rd_acc   = acc & (WREN == '0);
    wr_lane  = {NB{acc}} & WREN;
  end

  // -------------------------------------------------------------------------
  // Storage (not reset)
  // -------------------------------------------------------------------------
  logic [DW-1:0] mem [DEPTH];

`ifdef CMSDK_SRAM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] wpar;
  logic [NB-1:0] rpar_bad;

  always_comb begin
    wpar     = '0;
    rpar_bad = '0;
    for (int unsigned n = 0; n < NB; n++) begin
      wpar[n]     = (^WDATA[n*8 +: 8]) ^ PINJ;
      rpar_bad[n] = (^mem[ADDR][n*8 +: 8]) ^ par_mem[ADDR][n];
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (clearing) begin
      mem[clr_cnt_q] <= '0;
`ifdef CMSDK_SRAM_PARITY_EN
      par_mem[clr_cnt_q] <= '0;
`endif
    end else begin
      for (int unsigned n = 0; n < NB; n++) begin
        if (wr_lane[n]) begin
          mem[ADDR][n*8 +: 8] <= WDATA[n*8 +: 8];
`ifdef CMSDK_SRAM_PARITY_EN
          par_mem[ADDR][n] <= wpar[n];
`endif
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read pipeline; data is zeroed in stage 1 when no read is returned so the
  // output never needs a separate qualifying mux.
  // -------------------------------------------------------------------------
  logic          s1_vld_q, s1_vld_d;
  logic [DW-1:0] s1_data_q, s1_data_d;
`ifdef CMSDK_SRAM_PARITY_EN
  logic          s1_perr_q, s1_perr_d;
`endif

  always_comb begin
    s1_vld_d  = rd_acc;
    s1_data_d = rd_acc ? mem[ADDR] : '0;
`ifdef CMSDK_SRAM_PARITY_EN
    s1_perr_d = rd_acc & (|rpar_bad);
`endif
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      s1_vld_q  <= 1'b0;
      s1_data_q <= '0;
`ifdef CMSDK_SRAM_PARITY_EN
      s1_perr_q <= 1'b0;
`endif
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_data_q <= s1_data_d;
`ifdef CMSDK_SRAM_PARITY_EN
      s1_perr_q <= s1_perr_d;
`endif
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic          s2_vld_q;
    logic [DW-1:0] s2_data_q;
`ifdef CMSDK_SRAM_PARITY_EN
    logic          s2_perr_q;
`endif

    always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
        s2_vld_q  <= 1'b0;
        s2_data_q <= '0;
`ifdef CMSDK_SRAM_PARITY_EN
        s2_perr_q <= 1'b0;
`endif
      end else begin
        s2_vld_q  <= s1_vld_q;
        s2_data_q <= s1_data_q;
`ifdef CMSDK_SRAM_PARITY_EN
        s2_perr_q <= s1_perr_q;
`endif
      end
    end

    assign RVALID = s2_vld_q;
    assign RDATA  = s2_data_q;
`ifdef CMSDK_SRAM_PARITY_EN
    assign PERR   = s2_perr_q;
`endif
  end else begin : g_lat1
    assign RVALID = s1_vld_q;
    assign RDATA  = s1_data_q;
`ifdef CMSDK_SRAM_PARITY_EN
    assign PERR   = s1_perr_q;
`endif
  end

endmodule

// File: tb/tb_cmsdk_fpga_sram_ext.sv
`timescale 1ns/1ps
module tb_cmsdk_fpga_sram_ext;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int NB    = 4;
  localparam int DEPTH = 16;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] addr  = '0;
  logic [DW-1:0] wdata = '0;
  logic [NB-1:0] wren  = '0;
  logic          cs    = 1'b0;

  logic [DW-1:0] rdata1, rdata2, rdata3;
  logic          rv1, rv2, rv3;
  logic          rdy1, rdy2, rdy3;
`ifdef CMSDK_SRAM_PARITY_EN
  logic          pinj = 1'b0;
  logic          perr1, perr2, perr3;
`endif

  always #5 clk = ~clk;

  // dut1: latency 1 with fill, dut2: latency 2 with fill, dut3: no fill
  cmsdk_fpga_sram_ext #(.AW(AW), .DW(DW), .RD_LAT(1), .INIT_CLEAR(1)) dut1 (
    .CLK(clk), .RESETn(rst_n), .ADDR(addr), .WDATA(wdata), .WREN(wren), .CS(cs),
`ifdef CMSDK_SRAM_PARITY_EN
    .PINJ(pinj), .PERR(perr1),
`endif
    .RDATA(rdata1), .RVALID(rv1), .READY(rdy1));

  cmsdk_fpga_sram_ext #(.AW(AW), .DW(DW), .RD_LAT(2), .INIT_CLEAR(1)) dut2 (
    .CLK(clk), .RESETn(rst_n), .ADDR(addr), .WDATA(wdata), .WREN(wren), .CS(cs),
`ifdef CMSDK_SRAM_PARITY_EN
    .PINJ(pinj), .PERR(perr2),
`endif
    .RDATA(rdata2), .RVALID(rv2), .READY(rdy2));

  cmsdk_fpga_sram_ext #(.AW(AW), .DW(DW), .RD_LAT(1), .INIT_CLEAR(0)) dut3 (
    .CLK(clk), .RESETn(rst_n), .ADDR(addr), .WDATA(wdata), .WREN(wren), .CS(cs),
`ifdef CMSDK_SRAM_PARITY_EN
    .PINJ(pinj), .PERR(perr3),
`endif
    .RDATA(rdata3), .RVALID(rv3), .READY(rdy3));

  // Reference model: word array, per-lane "parity corrupted" flags, and one
  // history entry per clock edge describing what that edge's access returns.
  typedef struct packed {
    logic          v;
    logic [DW-1:0] d;
    logic          pe;
  } ret_t;

  logic [DW-1:0] mdl  [DEPTH];
  logic [NB-1:0] mbad [DEPTH];
  ret_t          hist [$];
  int            edges;
  int            n_pass = 0;
  int            n_chk  = 0;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      mdl[i]  = '0;
      mbad[i] = '0;
    end
    edges = 0;
    hist.delete();
    hist.push_back('0);
    hist.push_back('0);
  endtask

  // Advance one edge and apply the access to the model. The memory accepts
  // accesses once DEPTH edges have passed since reset release.
  task automatic tick();
    ret_t r;
    r = '0;
    @(posedge clk);
    if (rst_n && cs && edges >= DEPTH) begin
      if (wren == '0) begin
        r.v  = 1'b1;
        r.d  = mdl[addr];
        r.pe = |mbad[addr];
      end else begin
        for (int n = 0; n < NB; n++) begin
          if (wren[n]) begin
            mdl[addr][n*8 +: 8] = wdata[n*8 +: 8];
`ifdef CMSDK_SRAM_PARITY_EN
            mbad[addr][n] = pinj;
`endif
          end
        end
      end
    end
    if (rst_n) edges++;
    hist.push_back(r);
    #1;
  endtask

  task automatic test_reset();
    int cnt;
    cs = 1'b0; wren = '0; addr = '0; wdata = '0;
    rst_n = 1'b0;
    model_reset();
    #23;
    n_chk++;
    if ({rv1, rv2, rv3, rdy1, rdy2, rdy3} !== 6'b0 || rdata1 !== '0 || rdata2 !== '0 || rdata3 !== '0)
      $display("FAIL reset_outputs: rvalid=%b%b%b ready=%b%b%b rdata=%h/%h/%h required all zero",
               rv1, rv2, rv3, rdy1, rdy2, rdy3, rdata1, rdata2, rdata3);
    else n_pass++;
    rst_n = 1'b1;
    cnt = 0;
    while (rdy1 !== 1'b1 && cnt < 40) begin
      tick();
      cnt++;
      if (cnt == 1) begin
        n_chk++;
        if (rdy3 !== 1'b1 || rdy1 !== 1'b0)
          $display("FAIL ready_first_edge: noclear=%b clear=%b required 1/0", rdy3, rdy1);
        else n_pass++;
      end
    end
    n_chk++;
    if (cnt != DEPTH || rdy2 !== 1'b1)
      $display("FAIL clear_duration: got %0d cycles ready2=%b required %0d cycles ready2=1",
               cnt, rdy2, DEPTH);
    else n_pass++;
  endtask

  task automatic test_clear_zero();
    for (int a = 0; a < DEPTH; a++) begin
      cs = 1'b1; wren = '0; addr = AW'(a);
      tick();
      n_chk++;
      if (rv1 !== 1'b1 || rdata1 !== '0)
        $display("FAIL clear_zero addr %0d: rvalid=%b rdata=%h required 1/0", a, rv1, rdata1);
      else n_pass++;
    end
    cs = 1'b0;
    tick();
    n_chk++;
    if (rv1 !== 1'b0 || rv2 !== 1'b1 || rdata2 !== '0)
      $display("FAIL clear_zero tail: rv1=%b rv2=%b rdata2=%h required 0/1/0", rv1, rv2, rdata2);
    else n_pass++;
    tick();
  endtask

  task automatic test_write_read();
    cs = 1'b1; wren = 4'hF; addr = 4'd3; wdata = 32'hDEADBEEF;
    tick();
    n_chk++;
    if (rv1 !== 1'b0 || rdata1 !== '0)
      $display("FAIL write_no_rvalid: rvalid=%b rdata=%h required 0/0", rv1, rdata1);
    else n_pass++;
    wren = '0; wdata = '0;
    tick();
    n_chk++;
    if (rv1 !== 1'b1 || rdata1 !== 32'hDEADBEEF)
      $display("FAIL write_read: rvalid=%b rdata=%h required 1/deadbeef", rv1, rdata1);
    else n_pass++;
    cs = 1'b0;
    tick();
    n_chk++;
    if (rv1 !== 1'b0 || rdata1 !== '0 || rv2 !== 1'b1 || rdata2 !== 32'hDEADBEEF)
      $display("FAIL write_read_after: rv1=%b rdata1=%h rv2=%b rdata2=%h required 0/0/1/deadbeef",
               rv1, rdata1, rv2, rdata2);
    else n_pass++;
    tick();
  endtask

  task automatic test_byte_lanes();
    cs = 1'b1; wren = 4'hF; addr = 4'd5; wdata = 32'h11223344;
    tick();
    wren = 4'b0101; wdata = 32'hAABBCCDD;
    tick();
    wren = '0; wdata = '0;
    tick();
    n_chk++;
    if (rv1 !== 1'b1 || rdata1 !== 32'h11BB33DD)
      $display("FAIL byte_lanes: rvalid=%b rdata=%h required 1/11bb33dd", rv1, rdata1);
    else n_pass++;
    cs = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] e1d [6];
    logic [DW-1:0] e2d [6];
    logic [5:0]    e1v, e2v;
    e1v = 6'b000111;  // bit i = valid after read-phase edge i
    e2v = 6'b001110;
    e1d = '{32'hA, 32'hB, 32'hC, 32'h0, 32'h0, 32'h0};
    e2d = '{32'h0, 32'hA, 32'hB, 32'hC, 32'h0, 32'h0};
    cs = 1'b1; wren = 4'hF;
    for (int a = 0; a < 3; a++) begin
      addr = AW'(a); wdata = 32'hA + DW'(a);
      tick();
    end
    wren = '0; wdata = '0;
    for (int i = 0; i < 6; i++) begin
      cs = (i < 3); addr = AW'(i);
      tick();
      n_chk++;
      if (rv1 !== e1v[i] || rdata1 !== e1d[i] || rv2 !== e2v[i] || rdata2 !== e2d[i])
        $display("FAIL back_to_back cycle %0d: lat1 %b/%h lat2 %b/%h required %b/%h %b/%h",
                 i, rv1, rdata1, rv2, rdata2, e1v[i], e1d[i], e2v[i], e2d[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    ret_t e1, e2;
    for (int i = 0; i < 300; i++) begin
      cs    = ($urandom_range(0, 3) != 0);
      wren  = ($urandom_range(0, 1) != 0) ? NB'($urandom) : '0;
      addr  = AW'($urandom);
      wdata = $urandom;
`ifdef CMSDK_SRAM_PARITY_EN
      pinj  = ($urandom_range(0, 3) == 0);
`endif
      tick();
      e1 = hist[$];
      e2 = hist[$-1];
      n_chk++;
      if (rv1 !== e1.v || rdata1 !== e1.d || rv2 !== e2.v || rdata2 !== e2.d
`ifdef CMSDK_SRAM_PARITY_EN
          || perr1 !== e1.pe || perr2 !== e2.pe
`endif
         )
        $display("FAIL random cycle %0d: lat1 %b/%h lat2 %b/%h required %b/%h %b/%h",
                 i, rv1, rdata1, rv2, rdata2, e1.v, e1.d, e2.v, e2.d);
      else n_pass++;
    end
    cs = 1'b0; wren = '0;
`ifdef CMSDK_SRAM_PARITY_EN
    pinj = 1'b0;
`endif
    tick();
    tick();
  endtask

  task automatic test_reset_mid_clear();
    int cnt;
    cs = 1'b1; wren = '0; addr = 4'd3;
    tick();
    n_chk++;
    if (rv1 !== 1'b1)
      $display("FAIL flush_setup: rvalid=%b required 1", rv1);
    else n_pass++;
    cs = 1'b0;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (rv1 !== 1'b0 || rv2 !== 1'b0 || rdata1 !== '0 || rdata2 !== '0 || rdy1 !== 1'b0)
      $display("FAIL async_flush: rv=%b%b rdata=%h/%h ready=%b required all zero",
               rv1, rv2, rdata1, rdata2, rdy1);
    else n_pass++;
    model_reset();
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cs = 1'b1; wren = 4'hF; addr = AW'($urandom); wdata = $urandom;
      tick();
      n_chk++;
      if (rdy1 !== 1'b0 || rv1 !== 1'b0 || rv2 !== 1'b0)
        $display("FAIL during_clear %0d: ready=%b rvalid=%b%b required 0/00", i, rdy1, rv1, rv2);
      else n_pass++;
    end
    rst_n = 1'b0;
    #2;
    model_reset();
    rst_n = 1'b1;
    cnt = 0;
    while (rdy1 !== 1'b1 && cnt < 40) begin
      cs = 1'b1; wren = 4'hF; addr = AW'($urandom); wdata = $urandom;
      tick();
      cnt++;
    end
    cs = 1'b0; wren = '0;
    n_chk++;
    if (cnt != DEPTH || rdy2 !== 1'b1)
      $display("FAIL reclear_duration: got %0d cycles required %0d", cnt, DEPTH);
    else n_pass++;
    for (int a = 0; a < DEPTH; a++) begin
      cs = 1'b1; addr = AW'(a);
      tick();
      n_chk++;
      if (rv1 !== 1'b1 || rdata1 !== '0 || rv2 !== hist[$-1].v || rdata2 !== hist[$-1].d)
        $display("FAIL reclear_zero addr %0d: rv1=%b rdata1=%h rdata2=%h required 1/0/0",
                 a, rv1, rdata1, rdata2);
      else n_pass++;
    end
    cs = 1'b0;
    tick();
    tick();
  endtask

`ifdef CMSDK_SRAM_PARITY_EN
  task automatic test_parity();
    cs = 1'b1; wren = 4'b0001; addr = 4'd6; wdata = 32'h01; pinj = 1'b1;
    tick();
    wren = '0; pinj = 1'b0;
    tick();
    n_chk++;
    if (rv1 !== 1'b1 || perr1 !== 1'b1 || rdata1 !== 32'h01)
      $display("FAIL parity_inject: rvalid=%b perr=%b rdata=%h required 1/1/01", rv1, perr1, rdata1);
    else n_pass++;
    cs = 1'b0;
    tick();
    n_chk++;
    if (rv2 !== 1'b1 || perr2 !== 1'b1 || perr1 !== 1'b0)
      $display("FAIL parity_inject_lat2: rv2=%b perr2=%b perr1=%b required 1/1/0", rv2, perr2, perr1);
    else n_pass++;
    cs = 1'b1; wren = 4'b0001; wdata = 32'h01;
    tick();
    wren = '0;
    tick();
    n_chk++;
    if (rv1 !== 1'b1 || perr1 !== 1'b0)
      $display("FAIL parity_clean: rvalid=%b perr=%b required 1/0", rv1, perr1);
    else n_pass++;
    cs = 1'b0;
    tick();
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_clear_zero();
    test_write_read();
    test_byte_lanes();
    test_back_to_back();
    test_random();
    test_reset_mid_clear();
`ifdef CMSDK_SRAM_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
